// File: rtl/sprite_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sprite_move_ctrl
// Brief    : Keyboard-driven sprite step controller. On a frame tick with a
//            due move key it computes a candidate centre, bounds-checks it,
//            asks an external collision prober, and emits a one-cycle
//            displacement commit or silently rejects the move.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_move_ctrl #(
    parameter int STEP          = 1,
    parameter int SIZE          = 30,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 479,
    parameter int REPEAT_FRAMES = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       frame_tick_i,
    input  logic [7:0] keycode_i,
    input  logic [9:0] pos_x_i,
    input  logic [9:0] pos_y_i,
    output logic       probe_req_o,
    output logic [9:0] probe_x_o,
    output logic [9:0] probe_y_o,
    input  logic       probe_ack_i,
    input  logic       probe_blocked_i,
    output logic       step_valid_o,
    output logic [9:0] step_dx_o,
    output logic [9:0] step_dy_o,
    output logic       busy_o,
    output logic       overrun_o,
    output logic       timeout_err_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_PROBE  = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_REJECT = 3'd4;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_UP    = 8'h1A;

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int REP_W  = (REPEAT_FRAMES < 2) ? 1 : $clog2(REPEAT_FRAMES + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_FRAMES - 1);

    // Candidate arithmetic is done at 12 bits signed so a step past either
    // edge of the 10-bit coordinate space compares correctly.
    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic signed [11:0] X_LO   = 12'(X_MIN + SIZE);
    localparam logic signed [11:0] X_HI   = 12'(X_MAX - SIZE);
    localparam logic signed [11:0] Y_LO   = 12'(Y_MIN + SIZE);
    localparam logic signed [11:0] Y_HI   = 12'(Y_MAX - SIZE);

    logic [2:0]        state_q, state_d;
    logic [7:0]        key_q, key_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [9:0]        probe_x_q, probe_x_d;
    logic [9:0]        probe_y_q, probe_y_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic              is_move_key;
    logic              move_due;
    logic              timeout_hit;
    logic              out_of_bounds;
    logic signed [11:0] dir_x, dir_y;
    logic signed [11:0] cand_x, cand_y;

    // Move-due decision, direction decode and candidate bounds check
    always_comb begin
        is_move_key = (keycode_i == KEY_LEFT) || (keycode_i == KEY_RIGHT) ||
                      (keycode_i == KEY_DOWN) || (keycode_i == KEY_UP);
        // A different key than the one last latched is a fresh press; the
        // same key becomes due again once the repeat count is exhausted.
        move_due    = is_move_key && ((keycode_i != key_q) || (rep_q == REP_LAST));
        timeout_hit = (wait_q == WAIT_LAST);

        // Direction comes from the latched key so keycode changes after the
        // tick cannot alter a move already in flight.
        dir_x = 12'sd0;
        dir_y = 12'sd0;
        case (key_q)
            KEY_LEFT:  dir_x = -STEP_S;
            KEY_RIGHT: dir_x =  STEP_S;
            KEY_DOWN:  dir_y =  STEP_S;
            KEY_UP:    dir_y = -STEP_S;
            default: begin
                dir_x = 12'sd0;
                dir_y = 12'sd0;
            end
        endcase

        cand_x = $signed({2'b00, pos_x_i}) + dir_x;
        cand_y = $signed({2'b00, pos_y_i}) + dir_y;
        out_of_bounds = (cand_x < X_LO) || (cand_x > X_HI) ||
                        (cand_y < Y_LO) || (cand_y > Y_HI);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack is checked before the timeout so a late ack wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick_i && move_due) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = out_of_bounds ? S_REJECT : S_PROBE;
            end
            S_PROBE: begin
                if (probe_ack_i) begin
                    state_d = probe_blocked_i ? S_REJECT : S_COMMIT;
                end else if (timeout_hit) begin
                    state_d = S_REJECT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_REJECT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore outputs; displacement is forced to zero outside COMMIT
    always_comb begin
        busy_o       = (state_q != S_IDLE);
        probe_req_o  = (state_q == S_PROBE);
        step_valid_o = (state_q == S_COMMIT);
        step_dx_o    = 10'd0;
        step_dy_o    = 10'd0;
        if (state_q == S_COMMIT) begin
            step_dx_o = dir_x[9:0];
            step_dy_o = dir_y[9:0];
        end
        probe_x_o     = probe_x_q;
        probe_y_o     = probe_y_q;
        overrun_o     = overrun_q;
        timeout_err_o = timeout_q;
    end

    // Next values for key latch, repeat counter, probe wait counter and flags
    always_comb begin
        key_d     = key_q;
        rep_d     = rep_q;
        wait_d    = wait_q;
        probe_x_d = probe_x_q;
        probe_y_d = probe_y_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;

        // The repeat schedule only advances on ticks the controller accepts;
        // ticks that land while busy are dropped and flagged instead.
        if (frame_tick_i) begin
            if (state_q == S_IDLE) begin
                if (!is_move_key) begin
                    key_d = 8'h00;
                    rep_d = '0;
                end else if (move_due) begin
                    key_d = keycode_i;
                    rep_d = '0;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (state_q == S_CHECK) begin
            probe_x_d = cand_x[9:0];
            probe_y_d = cand_y[9:0];
            wait_d    = '0;
        end

        if ((state_q == S_PROBE) && !probe_ack_i) begin
            if (timeout_hit) begin
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q     <= 8'h00;
            rep_q     <= '0;
            wait_q    <= '0;
            probe_x_q <= 10'd0;
            probe_y_q <= 10'd0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            key_q     <= key_d;
            rep_q     <= rep_d;
            wait_q    <= wait_d;
            probe_x_q <= probe_x_d;
            probe_y_q <= probe_y_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_move_ctrl
// Brief    : Directed, table-driven bench for sprite_move_ctrl with
//            hand-written sequences for repeat, timeout and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_move_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic [7:0] keycode;
    logic [9:0] pos_x, pos_y;
    logic       probe_req;
    logic [9:0] probe_x, probe_y;
    logic       probe_ack, probe_blocked;
    logic       step_valid;
    logic [9:0] step_dx, step_dy;
    logic       busy, overrun, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sprite_move_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .frame_tick_i    (frame_tick),
        .keycode_i       (keycode),
        .pos_x_i         (pos_x),
        .pos_y_i         (pos_y),
        .probe_req_o     (probe_req),
        .probe_x_o       (probe_x),
        .probe_y_o       (probe_y),
        .probe_ack_i     (probe_ack),
        .probe_blocked_i (probe_blocked),
        .step_valid_o    (step_valid),
        .step_dx_o       (step_dx),
        .step_dy_o       (step_dy),
        .busy_o          (busy),
        .overrun_o       (overrun),
        .timeout_err_o   (timeout_err)
    );

    // kind: 0 = not a move key, 1 = rejected by bounds, 2 = goes to PROBE
    typedef struct {
        logic [7:0] key;
        logic [9:0] px;
        logic [9:0] py;
        int         kind;
        logic       blk;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [9:0] edx;
        logic [9:0] edy;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Tick with key 0 so the next move key is treated as a fresh press
    task automatic release_key();
        @(negedge clk);
        keycode    = 8'h00;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("release_idle", busy, 1'b0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        @(negedge clk);
        keycode    = v.key;
        pos_x      = v.px;
        pos_y      = v.py;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        if (v.kind == 0) begin
            check({t, "_busy"}, busy, 1'b0);
            check({t, "_valid"}, step_valid, 1'b0);
        end else begin
            check({t, "_check_busy"}, busy, 1'b1);
            check({t, "_check_req"}, probe_req, 1'b0);
            @(negedge clk);
            if (v.kind == 1) begin
                check({t, "_rej_req"}, probe_req, 1'b0);
                check({t, "_rej_busy"}, busy, 1'b1);
                check({t, "_rej_valid"}, step_valid, 1'b0);
            end else begin
                check({t, "_req"}, probe_req, 1'b1);
                check({t, "_px"}, probe_x, v.ex);
                check({t, "_py"}, probe_y, v.ey);
                check({t, "_probe_valid"}, step_valid, 1'b0);
                probe_ack     = 1'b1;
                probe_blocked = v.blk;
                @(negedge clk);
                probe_ack     = 1'b0;
                probe_blocked = 1'b0;
                check({t, "_valid"}, step_valid, !v.blk);
                check({t, "_dx"}, step_dx, v.edx);
                check({t, "_dy"}, step_dy, v.edy);
            end
            @(negedge clk);
            check({t, "_end_busy"}, busy, 1'b0);
            check({t, "_end_valid"}, step_valid, 1'b0);
            check({t, "_end_dx"}, step_dx, 10'd0);
        end
        release_key();
    endtask

    initial begin
        int  cnt;
        bit  done, saw, ok, got, acked;
        logic [9:0] dyv;

        vecs[0]  = '{8'h07, 10'd320, 10'd240, 2, 1'b0, 10'd321, 10'd240, 10'd1,     10'd0};
        vecs[1]  = '{8'h04, 10'd320, 10'd240, 2, 1'b0, 10'd319, 10'd240, 10'h3FF,   10'd0};
        vecs[2]  = '{8'h16, 10'd320, 10'd240, 2, 1'b0, 10'd320, 10'd241, 10'd0,     10'd1};
        vecs[3]  = '{8'h1A, 10'd320, 10'd240, 2, 1'b0, 10'd320, 10'd239, 10'd0,     10'h3FF};
        vecs[4]  = '{8'h1A, 10'd320, 10'd240, 2, 1'b1, 10'd320, 10'd239, 10'd0,     10'd0};
        vecs[5]  = '{8'h04, 10'd30,  10'd240, 1, 1'b0, 10'd0,   10'd0,   10'd0,     10'd0};
        vecs[6]  = '{8'h07, 10'd609, 10'd240, 1, 1'b0, 10'd0,   10'd0,   10'd0,     10'd0};
        vecs[7]  = '{8'h07, 10'd608, 10'd240, 2, 1'b0, 10'd609, 10'd240, 10'd1,     10'd0};
        vecs[8]  = '{8'h1A, 10'd320, 10'd30,  1, 1'b0, 10'd0,   10'd0,   10'd0,     10'd0};
        vecs[9]  = '{8'h16, 10'd320, 10'd449, 1, 1'b0, 10'd0,   10'd0,   10'd0,     10'd0};
        vecs[10] = '{8'h16, 10'd320, 10'd448, 2, 1'b0, 10'd320, 10'd449, 10'd0,     10'd1};
        vecs[11] = '{8'h05, 10'd320, 10'd240, 0, 1'b0, 10'd0,   10'd0,   10'd0,     10'd0};
        vecs[12] = '{8'h04, 10'd31,  10'd240, 2, 1'b0, 10'd30,  10'd240, 10'h3FF,   10'd0};

        rst_n = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
        pos_x = 10'd320; pos_y = 10'd240;
        probe_ack = 1'b0; probe_blocked = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_req", probe_req, 1'b0);
        check("rst_valid", step_valid, 1'b0);
        check("rst_dxdy", {step_dx, step_dy}, 20'd0);
        check("rst_flags", {overrun, timeout_err}, 2'b00);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(i, vecs[i]);
        end

        // Ack outside PROBE is ignored; ack on the last permitted wait cycle beats the timeout
        @(negedge clk);
        probe_ack = 1'b1;
        @(negedge clk);
        probe_ack = 1'b0;
        check("idle_ack_busy", busy, 1'b0);
        check("idle_ack_valid", step_valid, 1'b0);
        keycode = 8'h07; pos_x = 10'd320; pos_y = 10'd240; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        probe_ack  = 1'b1;
        @(negedge clk);
        probe_ack = 1'b0;
        check("check_ack_ignored", probe_req, 1'b1);
        ok = 1'b1;
        for (int i = 1; i < 255; i++) begin
            @(negedge clk);
            if (probe_req !== 1'b1) ok = 1'b0;
        end
        check("late_wait_req", ok, 1'b1);
        probe_ack = 1'b1;
        @(negedge clk);
        probe_ack = 1'b0;
        check("late_ack_valid", step_valid, 1'b1);
        check("late_ack_dx", step_dx, 10'd1);
        check("late_ack_no_timeout", timeout_err, 1'b0);
        release_key();

        // Held key auto-repeat: steps due on ticks 1, 9 and 17 only
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            keycode = 8'h16; pos_x = 10'd320; pos_y = 10'd240; frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            got = 1'b0; acked = 1'b0; dyv = 10'd0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                probe_ack = 1'b0;
                if (probe_req && !acked) begin
                    probe_ack = 1'b1;
                    acked = 1'b1;
                end
                if (step_valid) begin
                    got = 1'b1;
                    dyv = step_dy;
                end
            end
            probe_ack = 1'b0;
            check($sformatf("repeat_tick%0d", i), got, (i == 1) || (i == 9) || (i == 17));
            if ((i == 1) || (i == 9) || (i == 17)) begin
                check($sformatf("repeat_dy%0d", i), dyv, 10'd1);
            end
        end
        release_key();

        // Probe timeout with an extra tick dropped during the wait
        @(negedge clk);
        keycode = 8'h07; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("pre_overrun", overrun, 1'b0);
        cnt = 0; done = 1'b0; saw = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (!busy) begin
                done = 1'b1;
            end else begin
                if (probe_req) cnt++;
                if (step_valid) saw = 1'b1;
                if (probe_req && cnt == 10) frame_tick = 1'b1;
            end
        end
        frame_tick = 1'b0;
        check("timeout_bound", done, 1'b1);
        check("timeout_cycles", cnt, 255);
        check("timeout_err", timeout_err, 1'b1);
        check("overrun", overrun, 1'b1);
        check("timeout_no_step", saw, 1'b0);
        release_key();

        // Reset during PROBE, then the still-held key acts as a new press
        @(negedge clk);
        keycode = 8'h07; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        check("pre_rst_req", probe_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", probe_req, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_flags", {overrun, timeout_err}, 2'b00);
        check("async_rst_probe", {probe_x, probe_y}, 20'd0);
        check("async_rst_valid", step_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (step_valid) saw = 1'b1;
        end
        check("rst_abandon_no_step", saw, 1'b0);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        check("post_rst_req", probe_req, 1'b1);
        probe_ack = 1'b1;
        @(negedge clk);
        probe_ack = 1'b0;
        check("post_rst_valid", step_valid, 1'b1);
        check("post_rst_dx", step_dx, 10'd1);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
